// File: rtl/div_ctrl.sv
// div_ctrl: bus-mapped front end for the iterative unsigned divider core,
// handling sign conversion, div-by-zero/overflow shortcuts and core timeouts.
module div_ctrl #(
  parameter int TIMEOUT = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic [31:0] div_dv,
  output logic [31:0] div_dr,
  output logic        div_init,
  input  logic        div_ready,
  input  logic [31:0] div_result,
  output logic        irq
);
  typedef enum logic [2:0] {IDLE, PRE, LAUNCH, WAIT_LO, WAIT_HI, POST} state_t;
  state_t state;
  logic [31:0] dvnd, dvsr, quot, q, cnt, rdata;
  logic [2:0] sel;
  logic sgn, ie, busy, done, div0, ovf, tmo, neg, we, unused;
  assign unused = ^addr[1:0];
  assign irq = done & ie;
  always_comb begin
    sel = addr[4:2];
    we = cs & wr & ~busy;
    rdata = sel == 3'd0 ? dvnd :
            sel == 3'd1 ? dvsr :
            sel == 3'd2 ? {29'd0, ie, sgn, 1'b0} :
            sel == 3'd3 ? {27'd0, tmo, ovf, div0, done, busy} :
            sel == 3'd4 ? quot : 32'd0;
  end
  // Only IDLE has busy low, so any accepted start write comes from IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dvnd <= '0;
      dvsr <= '0;
      quot <= '0;
      q <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      ie <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      div0 <= 1'b0;
      ovf <= 1'b0;
      tmo <= 1'b0;
      neg <= 1'b0;
      d_out <= '0;
      div_dv <= '0;
      div_dr <= '0;
      div_init <= 1'b0;
    end else begin
      d_out <= cs & rd ? rdata : '0;
      div_init <= 1'b0;
      if (we && sel == 3'd0) dvnd <= d_in;
      if (we && sel == 3'd1) dvsr <= d_in;
      if (we && sel == 3'd2) begin
        sgn <= d_in[1];
        ie <= d_in[2];
      end
      case (state)
        IDLE: if (we && sel == 3'd2 && d_in[0]) begin
          done <= 1'b0;
          div0 <= 1'b0;
          ovf <= 1'b0;
          tmo <= 1'b0;
          busy <= 1'b1;
          state <= PRE;
        end
        PRE: begin
          cnt <= '0;
          if (dvsr == 32'd0) begin
            q <= 32'hFFFF_FFFF;
            div0 <= 1'b1;
            state <= POST;
          end else if (sgn && dvnd == 32'h8000_0000 && dvsr == 32'hFFFF_FFFF) begin
            q <= 32'h8000_0000;
            ovf <= 1'b1;
            state <= POST;
          end else begin
            div_dv <= sgn && dvnd[31] ? -dvnd : dvnd;
            div_dr <= sgn && dvsr[31] ? -dvsr : dvsr;
            neg <= sgn & (dvnd[31] ^ dvsr[31]);
            div_init <= 1'b1;
            state <= LAUNCH;
          end
        end
        LAUNCH: state <= WAIT_LO;
        WAIT_LO: if (!div_ready) begin
          cnt <= '0;
          state <= WAIT_HI;
        end else if (cnt == 32'd7) begin
          tmo <= 1'b1;
          q <= '0;
          state <= POST;
        end else cnt <= cnt + 32'd1;
        WAIT_HI: if (div_ready) begin
          q <= neg ? -div_result : div_result;
          state <= POST;
        end else if (cnt == 32'(TIMEOUT - 1)) begin
          tmo <= 1'b1;
          q <= '0;
          state <= POST;
        end else cnt <= cnt + 32'd1;
        POST: begin
          quot <= q;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
